// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IFU, read-only)
// and load/store (LSU, read/write). One transaction is in flight at a time;
// round-robin tie break; watchdog turns a hung slave into an error response.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_valid/if_ready/if_addr         IFU request handshake
//   if_rvalid/if_rdata/if_err         IFU response (one-cycle pulse, data held)
//   ls_valid/ls_ready/ls_addr/ls_wen/ls_wdata/ls_wmask   LSU request
//   ls_rvalid/ls_rdata/ls_err         LSU response (one-cycle pulse, data held)
//   m_valid/m_ready/m_addr/m_wen/m_wdata/m_wmask         slave request
//   m_rvalid/m_rdata                  slave response
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_err,
  input  logic            ls_valid,
  output logic            ls_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_wen,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_err,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [AW-1:0]   m_addr,
  output logic            m_wen,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The counter is 0 in the first REQ cycle; expiring when it holds TIMEOUT-2
  // puts the error response exactly TIMEOUT cycles after capture.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} own_t;

  state_t        state, state_nx;
  own_t          owner, rr_last;
  logic [CW-1:0] count;
  logic          gnt_if, gnt_ls, done, expire, to_resp;
  logic [DW-1:0] rsp_data;

  always_comb begin
    state_nx = state;
    gnt_if   = 1'b0;
    gnt_ls   = 1'b0;
    done     = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        gnt_if = if_valid && (!ls_valid || rr_last == OWN_LS);
        gnt_ls = ls_valid && (!if_valid || rr_last == OWN_IF);
        if (gnt_if || gnt_ls) state_nx = REQ;
      end
      REQ: begin
        // A response in the same cycle as acceptance completes directly.
        done   = m_ready && m_rvalid;
        expire = !done && (count == LAST);
        if (done || expire) state_nx = RESP;
        else if (m_ready)   state_nx = WAIT;
      end
      WAIT: begin
        done   = m_rvalid;
        expire = !done && (count == LAST);
        if (done || expire) state_nx = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ready is combinational from the valids; gated so it reads 0 during reset.
  assign if_ready  = rst && gnt_if;
  assign ls_ready  = rst && gnt_ls;
  assign if_rvalid = (state == RESP) && (owner == OWN_IF);
  assign ls_rvalid = (state == RESP) && (owner == OWN_LS);

  assign to_resp  = done || expire;
  assign rsp_data = (expire || m_wen) ? '0 : m_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      rr_last <= OWN_LS;
      count   <= '0;
    end else begin
      state <= state_nx;
      if (gnt_if || gnt_ls) begin
        owner   <= gnt_ls ? OWN_LS : OWN_IF;
        rr_last <= gnt_ls ? OWN_LS : OWN_IF;
        count   <= '0;
      end else if (state == REQ || state == WAIT) begin
        count <= count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wen   <= 1'b0;
      m_wdata <= '0;
      m_wmask <= '0;
    end else if (gnt_ls) begin
      m_valid <= 1'b1;
      m_addr  <= ls_addr;
      m_wen   <= ls_wen;
      m_wdata <= ls_wdata;
      m_wmask <= ls_wmask;
    end else if (gnt_if) begin
      m_valid <= 1'b1;
      m_addr  <= if_addr;
      m_wen   <= 1'b0;
      m_wdata <= '0;
      m_wmask <= '0;
    end else if (state == REQ && state_nx != REQ) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      if_err   <= 1'b0;
      ls_rdata <= '0;
      ls_err   <= 1'b0;
    end else if (to_resp) begin
      if (owner == OWN_IF) begin
        if_rdata <= rsp_data;
        if_err   <= expire;
      end else begin
        ls_rdata <= rsp_data;
        ls_err   <= expire;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8). Inputs change just after the
// falling edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk, rst;
  logic            if_valid, if_ready, if_rvalid, if_err;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            ls_valid, ls_ready, ls_wen, ls_rvalid, ls_err;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata, ls_rdata;
  logic [DW/8-1:0] ls_wmask;
  logic            m_valid, m_ready, m_wen, m_rvalid;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [DW/8-1:0] m_wmask;

  int total  = 0;
  int passed = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to the next cycle: wait for the falling edge (inputs then change).
  task automatic next();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ready"},  if_ready,  0);
    chk({tag, "_ls_ready"},  ls_ready,  0);
    chk({tag, "_if_rvalid"}, if_rvalid, 0);
    chk({tag, "_ls_rvalid"}, ls_rvalid, 0);
    chk({tag, "_if_rdata"},  if_rdata,  0);
    chk({tag, "_if_err"},    if_err,    0);
    chk({tag, "_ls_rdata"},  ls_rdata,  0);
    chk({tag, "_ls_err"},    ls_err,    0);
    chk({tag, "_m_valid"},   m_valid,   0);
    chk({tag, "_m_addr"},    m_addr,    0);
    chk({tag, "_m_wen"},     m_wen,     0);
    chk({tag, "_m_wdata"},   m_wdata,   0);
    chk({tag, "_m_wmask"},   m_wmask,   0);
  endtask

  initial begin
    rst = 1'b0;
    if_valid = 0; if_addr = '0;
    ls_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
    m_ready = 0; m_rvalid = 0; m_rdata = '0;

    // Reset state; a request during reset must not be acknowledged.
    next(); if_valid = 1; settle();
    chk_all_zero("reset");
    next(); if_valid = 0; rst = 1'b1; settle();
    chk("idle_if_ready", if_ready, 0);

    // IFU read alone, response two cycles after m_ready.
    next(); if_valid = 1; if_addr = 32'h8000_0000; settle();           // T
    chk("t1_if_ready", if_ready, 1);
    chk("t1_ls_ready", ls_ready, 0);
    next(); if_valid = 0; m_ready = 1; settle();                       // T+1
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_addr", m_addr, 32'h8000_0000);
    chk("t1_m_wen", m_wen, 0);
    next(); m_ready = 0; settle();                                     // T+2
    chk("t1_m_valid_drop", m_valid, 0);
    next(); m_rvalid = 1; m_rdata = 32'h0000_0413; settle();           // T+3
    chk("t1_early_rvalid", if_rvalid, 0);
    next(); m_rvalid = 0; m_rdata = '0; settle();                      // T+4
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'h0000_0413);
    chk("t1_if_err", if_err, 0);
    chk("t1_ls_rvalid", ls_rvalid, 0);
    next(); settle();                                                  // T+5
    chk("t1_pulse_end", if_rvalid, 0);
    chk("t1_rdata_hold", if_rdata, 32'h0000_0413);

    // Round-robin ties. rr_last is still IFU from test 1, so force a fresh
    // reset to reproduce the "after reset" tie.
    next(); rst = 1'b0; settle();
    next(); rst = 1'b1; settle();
    next(); if_valid = 1; if_addr = 32'h10; ls_valid = 1; ls_addr = 32'h100; settle();
    chk("rr1_if_ready", if_ready, 1);
    chk("rr1_ls_ready", ls_ready, 0);
    next(); if_valid = 0; m_ready = 1; m_rvalid = 1; m_rdata = 32'h11; settle();
    chk("rr1_m_addr", m_addr, 32'h10);
    chk("rr1_ls_ready_busy", ls_ready, 0);
    next(); m_ready = 0; m_rvalid = 0; settle();
    chk("rr1_if_rvalid", if_rvalid, 1);
    chk("rr1_if_rdata", if_rdata, 32'h11);
    chk("rr1_ls_ready_resp", ls_ready, 0);
    next(); if_valid = 1; if_addr = 32'h20; settle();
    chk("rr2_ls_ready", ls_ready, 1);
    chk("rr2_if_ready", if_ready, 0);
    next(); ls_valid = 0; m_ready = 1; m_rvalid = 1; m_rdata = 32'h22; settle();
    chk("rr2_m_addr", m_addr, 32'h100);
    next(); m_ready = 0; m_rvalid = 0; settle();
    chk("rr2_ls_rvalid", ls_rvalid, 1);
    chk("rr2_ls_rdata", ls_rdata, 32'h22);
    chk("rr2_if_rvalid", if_rvalid, 0);
    next(); ls_valid = 1; ls_addr = 32'h300; settle();
    chk("rr3_if_ready", if_ready, 1);
    chk("rr3_ls_ready", ls_ready, 0);
    next(); if_valid = 0; ls_valid = 0; m_ready = 1; m_rvalid = 1; m_rdata = 32'h33; settle();
    chk("rr3_m_addr", m_addr, 32'h20);
    next(); m_ready = 0; m_rvalid = 0; settle();
    chk("rr3_if_rvalid", if_rvalid, 1);
    chk("rr3_if_rdata", if_rdata, 32'h33);

    // LSU write with a stalled slave.
    next(); ls_valid = 1; ls_addr = 32'h8000_1000; ls_wen = 1;
    ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'h3; settle();
    chk("wr_ls_ready", ls_ready, 1);
    next(); ls_valid = 0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0; settle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m_ready = 1;
      settle();
      chk("wr_m_valid", m_valid, 1);
      chk("wr_m_addr", m_addr, 32'h8000_1000);
      chk("wr_m_wen", m_wen, 1);
      chk("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
      chk("wr_m_wmask", m_wmask, 4'h3);
      if (i < 3) next();
    end
    next(); m_ready = 0; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF; settle();
    chk("wr_wait_m_valid", m_valid, 0);
    next(); m_rvalid = 0; m_rdata = '0; settle();
    chk("wr_ls_rvalid", ls_rvalid, 1);
    chk("wr_ls_rdata", ls_rdata, 0);
    chk("wr_ls_err", ls_err, 0);

    // Timeout: slave never accepts.
    next(); settle();
    next(); ls_valid = 1; ls_addr = 32'h200; settle();                 // T
    chk("to_ls_ready", ls_ready, 1);
    next(); ls_valid = 0; settle();                                    // T+1
    for (int i = 1; i < 8; i++) begin
      chk("to_no_rvalid", ls_rvalid, 0);
      chk("to_m_valid_held", m_valid, 1);
      next(); settle();
    end
    m_rvalid = 1; m_rdata = 32'h5555_5555; settle();                   // T+8
    chk("to_ls_rvalid", ls_rvalid, 1);
    chk("to_ls_err", ls_err, 1);
    chk("to_ls_rdata", ls_rdata, 0);
    chk("to_m_valid_drop", m_valid, 0);
    next(); settle();                                                  // T+9
    chk("to_late_ls", ls_rvalid, 0);
    chk("to_late_if", if_rvalid, 0);
    next(); m_rvalid = 0; m_rdata = '0; settle();
    chk("to_late2_ls", ls_rvalid, 0);
    chk("to_err_hold", ls_err, 1);

    // Stray responses in IDLE.
    for (int i = 0; i < 3; i++) begin
      next(); m_rvalid = (i < 2); m_rdata = 32'h77; settle();
      chk("stray_if_rvalid", if_rvalid, 0);
      chk("stray_ls_rvalid", ls_rvalid, 0);
    end
    m_rvalid = 0;

    // Asynchronous reset while waiting for the slave.
    next(); if_valid = 1; if_addr = 32'h400; settle();
    next(); if_valid = 0; m_ready = 1; settle();
    next(); m_ready = 0; settle();
    chk("ar_in_wait", m_valid, 0);
    rst = 1'b0; settle();
    chk_all_zero("async_rst");
    next(); settle();
    next(); rst = 1'b1; m_rvalid = 1; m_rdata = 32'h99; settle();
    chk("ar_no_if_rvalid", if_rvalid, 0);
    next(); m_rvalid = 0; settle();
    chk("ar_no_if_rvalid2", if_rvalid, 0);
    chk("ar_no_ls_rvalid", ls_rvalid, 0);
    next(); if_valid = 1; if_addr = 32'h500; settle();
    chk("ar_new_if_ready", if_ready, 1);
    next(); if_valid = 0; m_ready = 1; settle();
    chk("ar_new_m_addr", m_addr, 32'h500);
    next(); m_ready = 0; m_rvalid = 1; m_rdata = 32'hABCD; settle();
    next(); m_rvalid = 0; settle();
    chk("ar_new_if_rvalid", if_rvalid, 1);
    chk("ar_new_if_rdata", if_rdata, 32'hABCD);
    chk("ar_new_if_err", if_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
